// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_INC  = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLAG_PARITY = 0;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_SIGN   = 2;
  localparam int FLAG_CARRY  = 3;
  localparam int FLAG_OVF    = 4;
  localparam int NUM_FLAGS   = 5;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock, WIDTH iterations.
// o_product carries the finished product combinationally in the cycle o_done is high.
module alu_shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  // Upper half accumulates; the multiplier drains out of the low half as it shifts right.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  end

  assign o_busy    = (r_cnt != '0);
  assign o_done    = (r_cnt == CW'(1));
  assign o_product = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= i_mcand;
      r_acc   <= {{WIDTH{1'b0}}, i_mplier};
      r_cnt   <= CW'(WIDTH);
    end else if (o_busy) begin
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered 16-opcode ALU with valid/ready handshakes and an iterative multiplier.
//   state   | meaning
//   ST_IDLE | accepting ops; single-cycle results registered on accept
//   ST_MUL  | multiplier iterating; input side stalled until the product lands
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             parity_flag,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag,
  output logic             overflow_flag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                 r_state;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_out;
  logic [WIDTH-1:0]       r_out_hi;
  logic [NUM_FLAGS-1:0]   r_flags;

  logic                   w_accept;
  logic                   w_mul_start;
  logic                   w_mul_busy;
  logic                   w_mul_done;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH:0]         w_ext;
  logic [WIDTH-1:0]       w_res;
  logic                   w_carry;
  logic                   w_ovf;
  logic [NUM_FLAGS-1:0]   w_flags;
  logic [NUM_FLAGS-1:0]   w_mul_flags;

  assign in_ready    = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (opcode == OP_MUL);

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_mcand   (in1),
    .i_mplier  (in2),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  always_comb begin
    w_ext   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_ext   = {1'b0, in1} + {1'b0, in2};
        w_res   = w_ext[WIDTH-1:0];
        w_carry = w_ext[WIDTH];
        w_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_res[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = in1 - in2;
        w_carry = (in2 > in1);
        w_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_res[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  w_res = in1 & in2;
      OP_NAND: w_res = ~(in1 & in2);
      OP_OR:   w_res = in1 | in2;
      OP_NOT:  w_res = ~in1;
      OP_XNOR: w_res = ~(in1 ^ in2);
      OP_SHL: begin
        w_res   = {in1[WIDTH-2:0], 1'b0};
        w_carry = in1[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, in1[WIDTH-1:1]};
        w_carry = in1[0];
      end
      OP_SAR: begin
        w_res   = {in1[WIDTH-1], in1[WIDTH-1:1]};
        w_carry = in1[0];
      end
      OP_ROL: begin
        w_res   = {in1[WIDTH-2:0], in1[WIDTH-1]};
        w_carry = in1[WIDTH-1];
      end
      OP_DEC: begin
        w_res   = in1 - ONE;
        w_carry = (in1 == '0);
        w_ovf   = in1[WIDTH-1] && !w_res[WIDTH-1];
      end
      OP_INC: begin
        w_ext   = {1'b0, in1} + {1'b0, ONE};
        w_res   = w_ext[WIDTH-1:0];
        w_carry = w_ext[WIDTH];
        w_ovf   = !in1[WIDTH-1] && w_res[WIDTH-1];
      end
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (in1 > in2)};
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (in1 == in2)};
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_flags                   = '0;
    w_flags[FLAG_PARITY]      = ~^w_res;
    w_flags[FLAG_ZERO]        = (w_res == '0);
    w_flags[FLAG_SIGN]        = w_res[WIDTH-1];
    w_flags[FLAG_CARRY]       = w_carry;
    w_flags[FLAG_OVF]         = w_ovf;
    w_mul_flags               = '0;
    w_mul_flags[FLAG_PARITY]  = ~^w_prod[WIDTH-1:0];
    w_mul_flags[FLAG_ZERO]    = (w_prod[WIDTH-1:0] == '0);
    w_mul_flags[FLAG_SIGN]    = w_prod[WIDTH-1];
    w_mul_flags[FLAG_CARRY]   = (w_prod[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (opcode == OP_MUL) begin
              // Accept implies any pending result was taken this edge.
              r_state     <= ST_MUL;
              r_out_valid <= 1'b0;
            end else begin
              r_out       <= w_res;
              r_out_hi    <= '0;
              r_flags     <= w_flags;
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_out       <= w_prod[WIDTH-1:0];
            r_out_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_flags     <= w_mul_flags;
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_out       = r_out;
  assign alu_out_hi    = r_out_hi;
  assign parity_flag   = r_flags[FLAG_PARITY];
  assign zero_flag     = r_flags[FLAG_ZERO];
  assign sign_flag     = r_flags[FLAG_SIGN];
  assign carry_flag    = r_flags[FLAG_CARRY];
  assign overflow_flag = r_flags[FLAG_OVF];

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [3:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_out;
  logic [W-1:0]  alu_out_hi;
  logic          parity_flag;
  logic          zero_flag;
  logic          sign_flag;
  logic          carry_flag;
  logic          overflow_flag;

  int tests_run = 0;
  int tests_failed = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in1           (in1),
    .in2           (in2),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_out       (alu_out),
    .alu_out_hi    (alu_out_hi),
    .parity_flag   (parity_flag),
    .zero_flag     (zero_flag),
    .sign_flag     (sign_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag)
  );

  always #5 clk = ~clk;

  // Flags packed as {valid, parity, zero, sign, carry, ovf} for compact comparisons.
  function automatic logic [5:0] obs_flags();
    return {out_valid, parity_flag, zero_flag, sign_flag, carry_flag, overflow_flag};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    opcode   = op;
    in1      = a;
    in2      = b;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    tests_run++;
    if ({out_valid, in_ready, alu_out, alu_out_hi} !== {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b r=%b out=%h hi=%h", out_valid, in_ready, alu_out, alu_out_hi);
    end
    tests_run++;
    if (obs_flags() !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000000", obs_flags());
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_wrap();
    out_ready = 1'b1;
    drive(4'd0, 32'hFFFF_FFFF, 32'h1);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_wrap_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (alu_out !== 32'h0 || alu_out_hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL add_wrap_out: got %h/%h want 0/0", alu_out_hi, alu_out);
    end
    tests_run++;
    if (obs_flags() !== 6'b1_1_1_0_1_0) begin
      tests_failed++;
      $display("FAIL add_wrap_flags: got %b want 111010", obs_flags());
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_wrap_drain: got valid %b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    drive(4'd0, 32'h7FFF_FFFF, 32'h1);
    step();
    tests_run++;
    if (alu_out !== 32'h8000_0000 || obs_flags() !== 6'b1_0_0_1_0_1) begin
      tests_failed++;
      $display("FAIL add_ovf: got %h flags %b want 80000000 flags 100101", alu_out, obs_flags());
    end
    drive(4'd1, 32'h0, 32'h1);
    step();
    in_valid = 1'b0;
    tests_run++;
    if (alu_out !== 32'hFFFF_FFFF || obs_flags() !== 6'b1_1_0_1_1_0) begin
      tests_failed++;
      $display("FAIL sub_borrow: got %h flags %b want ffffffff flags 110110", alu_out, obs_flags());
    end
    step();
  endtask

  task automatic test_ops();
    logic [3:0]  ops   [12];
    logic [31:0] a     [12];
    logic [31:0] b     [12];
    logic [31:0] exp_r [12];
    logic [1:0]  exp_co[12];
    ops = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd12, 4'd13, 4'd13, 4'd14, 4'd14};
    a   = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'hAAAAAAAA, 32'h80000001, 32'h80000001,
            32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd3};
    b   = '{32'hFF00FF00, 32'h0F0F0000, 32'h0, 32'h55555555, 32'h0, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'd3, 32'd5};
    exp_r  = '{32'h0FFF0FFF, 32'hFFFFF0F0, 32'hEDCBA987, 32'h0, 32'h2, 32'h40000000,
               32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h80000000, 32'h1, 32'h0};
    exp_co = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10,
               2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], a[i], b[i]);
      step();
      tests_run++;
      if ({out_valid, alu_out, alu_out_hi, carry_flag, overflow_flag} !== {1'b1, exp_r[i], 32'h0, exp_co[i]}) begin
        tests_failed++;
        $display("FAIL op_%0d: got v=%b %h hi=%h co=%b%b want %h co=%b",
                 ops[i], out_valid, alu_out, alu_out_hi, carry_flag, overflow_flag, exp_r[i], exp_co[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mul();
    logic saw_ready;
    logic saw_valid;
    saw_ready = 1'b0;
    saw_valid = 1'b0;
    out_ready = 1'b1;
    drive(4'd2, 32'hFFFF_FFFF, 32'h2);
    step();
    in_valid = 1'b0;
    in1 = 32'h1234_5678;
    in2 = 32'h9ABC_DEF0;
    for (int i = 1; i < W; i++) begin
      saw_ready |= in_ready;
      saw_valid |= out_valid;
      step();
    end
    saw_ready |= in_ready;
    tests_run++;
    if ({saw_ready, saw_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mul_busy: in_ready seen %b out_valid seen %b want 0/0", saw_ready, saw_valid);
    end
    step();
    tests_run++;
    if ({alu_out_hi, alu_out} !== 64'h1_FFFF_FFFE) begin
      tests_failed++;
      $display("FAIL mul_product: got %h_%h want 00000001_fffffffe", alu_out_hi, alu_out);
    end
    tests_run++;
    if (obs_flags() !== 6'b1_0_0_1_1_0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_flags: got %b ready %b want 100110 ready 1", obs_flags(), in_ready);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic stable_bad;
    stable_bad = 1'b0;
    out_ready = 1'b0;
    drive(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    drive(4'd0, 32'h1, 32'h2);
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_out !== 32'hF000_F000) stable_bad = 1'b1;
      step();
    end
    tests_run++;
    if (stable_bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_hold: got v=%b r=%b out=%h want 1/0/f000f000", out_valid, in_ready, alu_out);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || alu_out !== 32'h3) begin
      tests_failed++;
      $display("FAIL bp_new_result: got v=%b out=%h want 1/00000003", out_valid, alu_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4];
    logic [31:0] a   [4];
    logic [31:0] b   [4];
    logic [31:0] er  [4];
    logic        ec  [4];
    ops = '{4'd3, 4'd10, 4'd11, 4'd15};
    a   = '{32'h0F0F0F0F, 32'h80000001, 32'h80000001, 32'd5};
    b   = '{32'h00FF00FF, 32'h0, 32'h0, 32'd5};
    er  = '{32'h000F000F, 32'hC0000000, 32'h00000003, 32'h1};
    ec  = '{1'b0, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], a[i], b[i]);
      step();
      tests_run++;
      if ({out_valid, in_ready, alu_out, carry_flag} !== {1'b1, 1'b1, er[i], ec[i]}) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got v=%b r=%b %h c=%b want %h c=%b",
                 i, out_valid, in_ready, alu_out, carry_flag, er[i], ec[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mul();
    logic late_valid;
    late_valid = 1'b0;
    out_ready = 1'b1;
    drive(4'd2, 32'd3, 32'd5);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({out_valid, in_ready, alu_out, alu_out_hi, obs_flags()} !== {1'b0, 1'b1, {2*W{1'b0}}, 6'b0}) begin
      tests_failed++;
      $display("FAIL rst_mul_abort: got v=%b r=%b out=%h hi=%h flags=%b", out_valid, in_ready, alu_out, alu_out_hi, obs_flags());
    end
    rst = 1'b0;
    repeat (W + 4) begin
      late_valid |= out_valid;
      step();
    end
    tests_run++;
    if (late_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mul_no_output: saw out_valid %b want 0", late_valid);
    end
    drive(4'd0, 32'd3, 32'd4);
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || alu_out !== 32'd7) begin
      tests_failed++;
      $display("FAIL rst_mul_add: got v=%b out=%h want 1/00000007", out_valid, alu_out);
    end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    opcode    = 4'd0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_add_wrap();
    test_overflow();
    test_ops();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU. Same 16-opcode set with WIDTH-generic datapath.
- Valid/ready handshakes on input and output, and a multi-cycle shift-add multiplier returning the full 2*WIDTH product.
- Per-opcode carry and overflow flags, all registered with the result.
- Sits between operand-fetch and writeback; downstream back-pressure is honoured.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8 to 64.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept; transfer when in_valid && in_ready
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B
- opcode  in  4  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- alu_out  out  WIDTH  result (multiply: low half)
- alu_out_hi  out  WIDTH  multiply high half; 0 for all other ops
- parity_flag  out  1  even parity: ~^alu_out
- zero_flag  out  1  alu_out == 0
- sign_flag  out  1  alu_out[WIDTH-1]
- carry_flag  out  1  per-opcode, see Behaviour
- overflow_flag  out  1  signed overflow, see Behaviour

Behaviour:
- Reset: state IDLE, out_valid=0, alu_out=0, alu_out_hi=0, all flags 0, multiplier counter 0. Reset during MUL aborts the operation with no output.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Sustains one op per cycle for single-cycle ops under continuous out_ready.
- Opcodes (unsigned unless noted):
  - 0: add
  - 1: sub
  - 2: mul
  - 3: and
  - 4: nand
  - 5: or
  - 6: not in1
  - 7: xnor
  - 8: shl1, zero fill
  - 9: shr1, zero fill
  - 10: sar1
  - 11: rol1
  - 12: in1-1
  - 13: in1+1
  - 14: in1>in2 (1/0, zero-extended)
  - 15: in1==in2 (1/0, zero-extended)
- Carry:
  - add/inc: carry out of bit WIDTH-1.
  - sub/dec: borrow (1 when the subtrahend exceeds in1).
  - shl1/rol1: in1[WIDTH-1].
  - shr1/sar1: in1[0].
  - mul: alu_out_hi != 0.
  - All others: 0.
- Overflow: two's-complement overflow for add/sub/inc/dec; 0 otherwise.
- Single-cycle ops: accepted at edge N → result and flags registered at edge N; out_valid visible from cycle N+1.
- Multiply:
  - Accept at edge N loads the multiplicand, multiplier and a 2*WIDTH accumulator; state becomes MUL.
  - One shift-add iteration per edge, N+1..N+WIDTH. Final iteration writes alu_out/alu_out_hi/flags and sets out_valid; state returns to IDLE.
  - Latency is WIDTH cycles; in_ready=0 throughout MUL.
- FSM transitions:
  - IDLE→MUL on accepted mul.
  - MUL→IDLE after WIDTH iterations.
  - No other states.
- Output hold: while out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Output handshake: out_ready with no new accept clears out_valid at the next edge. Simultaneous output handshake and single-cycle input accept replaces the result, and out_valid stays 1.
- Operand capture: inputs are sampled only at accept; operand changes afterward have no effect.
- Wrap-around: add/inc/sub/dec wrap modulo 2^WIDTH.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_EQ (4'd0..4'd15)
  - FSM state encoding (IDLE, MUL)
  - flag-index constants
- Sub-module alu_shift_add_mul: WIDTH-parametrised iterative multiplier with start/busy/done, product[2*WIDTH-1:0], and internal counter; the top instantiates one.
- Top holds the handshake, the single-cycle datapath, flag generation and output registers.

Test Plan:
- WIDTH=32, add in1=0xFFFFFFFF in2=0x1 → out_valid 1 cycle after accept, alu_out=0, zero=1, carry=1, overflow=0, parity=1.
- Add 0x7FFFFFFF+0x1 → alu_out=0x80000000, sign=1, overflow=1, carry=0; sub 0x0-0x1 → 0xFFFFFFFF, carry(borrow)=1.
- Mul 0xFFFFFFFF*0x2 → out_valid exactly 32 cycles after accept, alu_out=0xFFFFFFFE, alu_out_hi=0x1, carry=1; in_ready=0 for all 32 cycles.
- Back-pressure: out_ready=0 after a result, in_valid held with new op → in_ready=0 and outputs stable; raise out_ready → new result one cycle later.
- Throughput: 4 back-to-back ops (and, sar1 0x80000001 → 0xC0000000 carry=1, rol1 0x80000001 → 0x00000003 carry=1, eq 5,5 → 1) with out_ready=1 → one result per cycle, in order.
- Assert rst 10 cycles into a mul → next cycle out_valid=0, in_ready=1, all outputs 0; subsequent add 3+4 → 7.
